// File: rtl/data_mem.sv
// data_mem: 64 KiB mixed-width true dual-port data RAM.
// Port A is a byte port (byte address), port B is a 32-bit word port
// (word address). Both share one clock and one array of 32-bit words,
// each word split into four little-endian byte lanes.
//
// Read behaviour:
//   - Both ports read every cycle with one cycle of latency; q holds
//     between edges.
//   - A port that writes sees its own write data on q (write-through).
//   - A port that reads a location the other port writes in the same cycle
//     sees the old contents. The new data shows from the next edge onward.
//
// Collision: when both ports write the same byte in one cycle, port B's
// byte is stored. Port A's q still shows its own data_a (write-through).
//
// Reset clears only the output registers. The array is neither cleared
// nor written while reset is high.
module data_mem #(
  parameter int ADDR_A_W  = 16,
  parameter int ADDR_B_W  = 14,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_A_W-1:0] address_a,
  input  logic [7:0]          data_a,
  input  logic                wren_a,
  output logic [7:0]          q_a,
  input  logic [ADDR_B_W-1:0] address_b,
  input  logic [31:0]         data_b,
  input  logic                wren_b,
  output logic [31:0]         q_b
);

  localparam int WORDS = 1 << ADDR_B_W;

  // Power-up contents: all zero, or left undefined when INIT_ZERO is 0.
  logic [31:0] mem [WORDS] = '{default: (INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx)};

  logic [ADDR_B_W-1:0] word_a;
  logic [1:0]          lane_a;
  logic [31:0]         rd_word_a;
  logic [7:0]          rd_byte_a;

  assign word_a = address_a[ADDR_A_W-1:2];
  assign lane_a = address_a[1:0];

  // Select the addressed byte lane from the stored word.
  always_comb begin
    rd_word_a = mem[word_a];
    rd_byte_a = 8'h00;
    case (lane_a)
      2'd0:    rd_byte_a = rd_word_a[7:0];
      2'd1:    rd_byte_a = rd_word_a[15:8];
      2'd2:    rd_byte_a = rd_word_a[23:16];
      default: rd_byte_a = rd_word_a[31:24];
    endcase
  end

  // Array update. Port B is applied last so it wins any byte both ports write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wren_a) begin
        mem[word_a][{lane_a, 3'b000} +: 8] <= data_a;
      end
      if (wren_b) begin
        mem[address_b] <= data_b;
      end
    end
  end

  // Registered read data. The array is read before this edge's writes land,
  // which gives the other port the old data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_a <= 8'h00;
      q_b <= 32'h0000_0000;
    end else begin
      q_a <= wren_a ? data_a : rd_byte_a;
      q_b <= wren_b ? data_b : mem[address_b];
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed test of data_mem. A driver issues one access per
// cycle and pushes the expected q values. A monitor pops and compares them
// one cycle later.
module tb_data_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address_a = '0;
  logic [7:0]  data_a = '0;
  logic        wren_a = 1'b0;
  logic [7:0]  q_a;
  logic [13:0] address_b = '0;
  logic [31:0] data_b = '0;
  logic        wren_b = 1'b0;
  logic [31:0] q_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry is {check_a, check_b, exp_a[7:0], exp_b[31:0]}.
  logic [41:0] exp_q[$];

  data_mem dut (
    .clock     (clock),
    .reset     (reset),
    .address_a (address_a),
    .data_a    (data_a),
    .wren_a    (wren_a),
    .q_a       (q_a),
    .address_b (address_b),
    .data_b    (data_b),
    .wren_b    (wren_b),
    .q_b       (q_b)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present one access at the falling edge and queue its expectations.
  task automatic step(input logic [15:0] aa, input logic [7:0] da, input logic wa,
                      input logic [13:0] ab, input logic [31:0] db, input logic wb,
                      input logic ca, input logic [7:0] ea,
                      input logic cb, input logic [31:0] eb);
    @(negedge clock);
    address_a = aa;
    data_a    = da;
    wren_a    = wa;
    address_b = ab;
    data_b    = db;
    wren_b    = wb;
    exp_q.push_back({ca, cb, ea, eb});
  endtask

  // Read-only access on both ports.
  task automatic rd(input logic [15:0] aa, input logic ca, input logic [7:0] ea,
                    input logic [13:0] ab, input logic cb, input logic [31:0] eb);
    step(aa, 8'h00, 1'b0, ab, 32'h0, 1'b0, ca, ea, cb, eb);
  endtask

  // Monitor: compare q one step after the edge that sampled the access.
  always @(posedge clock) begin
    logic [41:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[41]) check8("q_a", q_a, e[39:32]);
      if (e[40]) check32("q_b", q_b, e[31:0]);
    end
  end

  initial begin
    // Reset: outputs go to zero immediately, without waiting for a clock edge.
    address_a = 16'h1234;
    address_b = 14'h0123;
    #1 reset = 1'b1;
    #1;
    check8("reset_q_a_async", q_a, 8'h00);
    check32("reset_q_b_async", q_b, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check8("reset_q_a_hold", q_a, 8'h00);
    check32("reset_q_b_hold", q_b, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Locations nobody has written read back as zero.
    rd(16'd100, 1'b1, 8'h00, 14'd50, 1'b1, 32'h0);

    // Port B writes a word while port A reads a byte of it (A sees old data).
    step(16'd0, 8'h00, 1'b0, 14'd0, 32'h0000_0001, 1'b1, 1'b1, 8'h00, 1'b1, 32'h0000_0001);
    rd(16'd0, 1'b1, 8'h01, 14'd0, 1'b1, 32'h0000_0001);
    rd(16'd1, 1'b1, 8'h00, 14'd0, 1'b1, 32'h0000_0001);
    rd(16'd2, 1'b1, 8'h00, 14'd0, 1'b1, 32'h0000_0001);
    rd(16'd3, 1'b1, 8'h00, 14'd0, 1'b1, 32'h0000_0001);

    // Port A writes bytes, port B reads the words back.
    step(16'd0, 8'h01, 1'b1, 14'd0, 32'h0, 1'b0, 1'b1, 8'h01, 1'b1, 32'h0000_0001);
    rd(16'd0, 1'b1, 8'h01, 14'd0, 1'b1, 32'h0000_0001);
    step(16'd8, 8'h5A, 1'b1, 14'd2, 32'h0, 1'b0, 1'b1, 8'h5A, 1'b1, 32'h0000_0000);
    rd(16'd8, 1'b1, 8'h5A, 14'd2, 1'b1, 32'h0000_005A);
    step(16'h0007, 8'hAB, 1'b1, 14'd1, 32'h0, 1'b0, 1'b1, 8'hAB, 1'b1, 32'h0000_0000);
    rd(16'd4, 1'b1, 8'h00, 14'd1, 1'b1, 32'hAB00_0000);

    // Lane mapping: bits 15:8 of a word belong to byte address 1.
    step(16'd4, 8'h00, 1'b0, 14'd0, 32'h0000_0800, 1'b1, 1'b1, 8'h00, 1'b1, 32'h0000_0800);
    rd(16'd1, 1'b1, 8'h08, 14'd0, 1'b1, 32'h0000_0800);
    rd(16'd0, 1'b1, 8'h00, 14'd2, 1'b1, 32'h0000_005A);

    // Port B writes word 5 while port A reads byte 20 of that word.
    step(16'd20, 8'h00, 1'b0, 14'd5, 32'h1122_3344, 1'b1, 1'b1, 8'h00, 1'b1, 32'h1122_3344);
    rd(16'd20, 1'b1, 8'h44, 14'd5, 1'b1, 32'h1122_3344);
    rd(16'd23, 1'b1, 8'h11, 14'd5, 1'b1, 32'h1122_3344);

    // Both ports write the same byte: port B's data is stored.
    step(16'd20, 8'hFF, 1'b1, 14'd5, 32'hAABB_CCDD, 1'b1, 1'b0, 8'h00, 1'b1, 32'hAABB_CCDD);
    rd(16'd20, 1'b1, 8'hDD, 14'd5, 1'b1, 32'hAABB_CCDD);

    // Port A writes a byte of word 5 while port B reads it (B sees old data).
    step(16'd22, 8'h77, 1'b1, 14'd5, 32'h0, 1'b0, 1'b1, 8'h77, 1'b1, 32'hAABB_CCDD);
    rd(16'd22, 1'b1, 8'h77, 14'd5, 1'b1, 32'hAA77_CCDD);

    // Both ports write different words in the same cycle.
    step(16'd40, 8'h12, 1'b1, 14'd6, 32'hCAFE_F00D, 1'b1, 1'b1, 8'h12, 1'b1, 32'hCAFE_F00D);
    rd(16'd24, 1'b1, 8'h0D, 14'd10, 1'b1, 32'h0000_0012);
    rd(16'd27, 1'b1, 8'hCA, 14'd6, 1'b1, 32'hCAFE_F00D);

    // Let the monitor drain before starting the mid-operation reset.
    @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_before_reset: %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end

    // Reset between edges while port B is writing: no write takes effect.
    @(negedge clock);
    address_a = 16'd21;
    address_b = 14'd5;
    data_b    = 32'hDEAD_BEEF;
    wren_b    = 1'b1;
    data_a    = 8'h99;
    wren_a    = 1'b1;
    #2 reset = 1'b1;
    #1;
    check8("midreset_q_a_async", q_a, 8'h00);
    check32("midreset_q_b_async", q_b, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check8("midreset_q_a_hold", q_a, 8'h00);
    check32("midreset_q_b_hold", q_b, 32'h0);
    @(negedge clock);
    reset  = 1'b0;
    wren_a = 1'b0;
    wren_b = 1'b0;

    // Contents written before the reset are intact.
    rd(16'd21, 1'b1, 8'hCC, 14'd5, 1'b1, 32'hAA77_CCDD);
    rd(16'd23, 1'b1, 8'hAA, 14'd6, 1'b1, 32'hCAFE_F00D);

    // Bounded wait for the monitor to consume every pending expectation.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_final: %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
